// File: rtl/vx_tcu_drl_align_round_if.sv
// Beat bus between the TCU DRL mul/exp stage, the align/round block and writeback.
// The producer side (master) drives the beat and ready_out; the block (slave) returns results.
interface vx_tcu_drl_align_round_if #(
  parameter int TCK   = 4,
  parameter int W     = 25,
  parameter int EXP_W = 10
);
  typedef struct packed {
    logic nan;
    logic inf;
    logic sign;
  } fedp_excep_t;

  logic                    valid_in;
  logic                    ready_in;
  logic [31:0]             req_id;
  logic [EXP_W-1:0]        max_exp;
  logic [TCK:0][7:0]       shift_amt;
  logic [TCK:0][W-1:0]     raw_sigs;
  logic [TCK-1:0]          lane_mask;
  fedp_excep_t             exceptions;
  logic                    valid_out;
  logic                    ready_out;
  logic [31:0]             result;
  logic [31:0]             req_id_out;

  modport master (
    output valid_in, req_id, max_exp, shift_amt, raw_sigs, lane_mask, exceptions, ready_out,
    input  ready_in, valid_out, result, req_id_out
  );

  modport slave (
    input  valid_in, req_id, max_exp, shift_amt, raw_sigs, lane_mask, exceptions, ready_out,
    output ready_in, valid_out, result, req_id_out
  );
endinterface

// File: rtl/vx_tcu_drl_align_round.sv
// Align, sum, normalise and RNE-round TCK products plus C into one FP32 result; 3-cycle latency.
// Whole pipe freezes while the result is held (valid_out & ~ready_out); ready_in drops for that cycle.
module vx_tcu_drl_align_round #(
  parameter int TCK      = 4,
  parameter int W        = 25,
  parameter int EXP_W    = 10,
  parameter int FRAC_W   = 22,
  parameter int EXP_BIAS = 127,
  parameter int GUARD    = 3
) (
  input  logic                    clk,
  input  logic                    reset_n,
  vx_tcu_drl_align_round_if.slave bus
);
  localparam int ACC_W = W + GUARD + $clog2(TCK + 1) + 1;
  localparam int PW    = $clog2(ACC_W);
  localparam int EW    = EXP_W + 2;
  localparam int NAN_B = 2;
  localparam int INF_B = 1;
  localparam int SGN_B = 0;
  localparam logic signed [EW-1:0] E_OFS  = EW'(127 - EXP_BIAS - FRAC_W - GUARD);
  localparam logic signed [EW-1:0] E_MAX  = EW'(255);
  localparam logic signed [EW-1:0] E_ZERO = '0;

  logic                      s1_vld_q, s1_vld_d, s2_vld_q, s2_vld_d, out_vld_q, out_vld_d;
  logic [TCK:0][ACC_W-1:0]   s1_lane_q, s1_lane_d;
  logic [TCK:0]              s1_sticky_q, s1_sticky_d;
  logic [EXP_W-1:0]          s1_exp_q, s1_exp_d, s2_exp_q, s2_exp_d;
  logic [2:0]                s1_exc_q, s1_exc_d, s2_exc_q, s2_exc_d;
  logic [31:0]               s1_id_q, s1_id_d, s2_id_q, s2_id_d, out_id_q, out_id_d;
  logic [ACC_W-1:0]          s2_acc_q, s2_acc_d;
  logic                      s2_sticky_q, s2_sticky_d;
  logic [31:0]               out_res_q, out_res_d;

  logic                      stall, adv;
  logic [TCK:0]              lane_act;
  logic [TCK:0][ACC_W-1:0]   lane_v;
  logic [TCK:0]              lane_st;
  logic [ACC_W-1:0]          acc_sum;
  logic [31:0]               res;

  assign stall          = out_vld_q & ~bus.ready_out;
  assign adv            = ~stall;
  assign bus.ready_in   = adv;
  assign bus.valid_out  = out_vld_q;
  assign bus.result     = out_res_q;
  assign bus.req_id_out = out_id_q;
  assign lane_act       = {1'b1, bus.lane_mask};

  // S1: align each lane to the common exponent, remembering any bits shifted out.
  always_comb begin
    logic [ACC_W-1:0] ext;
    ext     = '0;
    lane_v  = '0;
    lane_st = '0;
    for (int i = 0; i <= TCK; i++) begin
      ext = ACC_W'($signed(bus.raw_sigs[i])) << GUARD;
      if (lane_act[i]) begin
        if (bus.shift_amt[i] >= 8'(ACC_W)) begin
          lane_v[i]  = {ACC_W{ext[ACC_W-1]}};
          lane_st[i] = |bus.raw_sigs[i];
        end else begin
          lane_v[i]  = $signed(ext) >>> bus.shift_amt[i];
          lane_st[i] = |(ext & ~({ACC_W{1'b1}} << bus.shift_amt[i]));
        end
      end
    end
  end

  // S2: ACC_W has headroom for TCK+1 lanes, so the plain sum cannot overflow.
  always_comb begin
    acc_sum = '0;
    for (int i = 0; i <= TCK; i++) begin
      acc_sum = acc_sum + s1_lane_q[i];
    end
  end

  // S3: normalise the magnitude so its leading one sits at the top, then round to nearest even.
  always_comb begin
    logic                 sgn, grd, stk, inc;
    logic [ACC_W-1:0]     mag, norm;
    logic [PW-1:0]        msb;
    logic [22:0]          mant;
    logic [23:0]          mant_r;
    logic signed [EW-1:0] exp_n, exp_r;
    sgn    = s2_acc_q[ACC_W-1];
    mag    = sgn ? (ACC_W'(0) - s2_acc_q) : s2_acc_q;
    msb    = '0;
    for (int i = 0; i < ACC_W; i++) begin
      if (mag[i]) msb = PW'(i);
    end
    norm   = mag << (PW'(ACC_W - 1) - msb);
    mant   = norm[ACC_W-2 -: 23];
    grd    = norm[ACC_W-25];
    stk    = (|norm[ACC_W-26:0]) | s2_sticky_q;
    inc    = grd & (stk | mant[0]);
    mant_r = {1'b0, mant} + {23'b0, inc};
    exp_n  = $signed(EW'(s2_exp_q)) + $signed(EW'(msb)) + E_OFS;
    exp_r  = exp_n + $signed(EW'(mant_r[23]));
    if (s2_exc_q[NAN_B])        res = 32'h7FC0_0000;
    else if (s2_exc_q[INF_B])   res = {s2_exc_q[SGN_B], 8'hFF, 23'b0};
    else if (mag == '0)         res = 32'h0000_0000;
    else if (exp_r >= E_MAX)    res = {sgn, 8'hFF, 23'b0};
    else if (exp_r <= E_ZERO)   res = {sgn, 31'b0};
    else                        res = {sgn, exp_r[7:0], mant_r[22:0]};
  end

  always_comb begin
    s1_vld_d    = s1_vld_q;
    s1_lane_d   = s1_lane_q;
    s1_sticky_d = s1_sticky_q;
    s1_exp_d    = s1_exp_q;
    s1_exc_d    = s1_exc_q;
    s1_id_d     = s1_id_q;
    s2_vld_d    = s2_vld_q;
    s2_acc_d    = s2_acc_q;
    s2_sticky_d = s2_sticky_q;
    s2_exp_d    = s2_exp_q;
    s2_exc_d    = s2_exc_q;
    s2_id_d     = s2_id_q;
    out_vld_d   = out_vld_q;
    out_res_d   = out_res_q;
    out_id_d    = out_id_q;
    if (adv) begin
      s1_vld_d  = bus.valid_in;
      s2_vld_d  = s1_vld_q;
      out_vld_d = s2_vld_q;
      if (bus.valid_in) begin
        s1_lane_d   = lane_v;
        s1_sticky_d = lane_st;
        s1_exp_d    = bus.max_exp;
        s1_exc_d    = bus.exceptions;
        s1_id_d     = bus.req_id;
      end
      if (s1_vld_q) begin
        s2_acc_d    = acc_sum;
        s2_sticky_d = |s1_sticky_q;
        s2_exp_d    = s1_exp_q;
        s2_exc_d    = s1_exc_q;
        s2_id_d     = s1_id_q;
      end
      if (s2_vld_q) begin
        out_res_d = res;
        out_id_d  = s2_id_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      s1_vld_q    <= 1'b0;
      s1_lane_q   <= '0;
      s1_sticky_q <= '0;
      s1_exp_q    <= '0;
      s1_exc_q    <= '0;
      s1_id_q     <= '0;
      s2_vld_q    <= 1'b0;
      s2_acc_q    <= '0;
      s2_sticky_q <= 1'b0;
      s2_exp_q    <= '0;
      s2_exc_q    <= '0;
      s2_id_q     <= '0;
      out_vld_q   <= 1'b0;
      out_res_q   <= '0;
      out_id_q    <= '0;
    end else begin
      s1_vld_q    <= s1_vld_d;
      s1_lane_q   <= s1_lane_d;
      s1_sticky_q <= s1_sticky_d;
      s1_exp_q    <= s1_exp_d;
      s1_exc_q    <= s1_exc_d;
      s1_id_q     <= s1_id_d;
      s2_vld_q    <= s2_vld_d;
      s2_acc_q    <= s2_acc_d;
      s2_sticky_q <= s2_sticky_d;
      s2_exp_q    <= s2_exp_d;
      s2_exc_q    <= s2_exc_d;
      s2_id_q     <= s2_id_d;
      out_vld_q   <= out_vld_d;
      out_res_q   <= out_res_d;
      out_id_q    <= out_id_d;
    end
  end
endmodule

// File: tb/tb_vx_tcu_drl_align_round.sv
// Directed bench for vx_tcu_drl_align_round: single beats with hand-computed FP32 results,
// a back-to-back burst under output backpressure, and reset with beats in flight.
module tb_vx_tcu_drl_align_round;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   n_checks = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  vx_tcu_drl_align_round_if bus ();
  vx_tcu_drl_align_round dut (.clk(clk), .reset_n(reset_n), .bus(bus));

  localparam logic [24:0] ONE  = 25'h040_0000;
  localparam logic [24:0] MONE = 25'h1C0_0000;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic clear_beat();
    bus.valid_in   = 1'b0;
    bus.req_id     = '0;
    bus.max_exp    = 10'd127;
    bus.shift_amt  = '0;
    bus.raw_sigs   = '0;
    bus.lane_mask  = '0;
    bus.exceptions = '0;
  endtask

  task automatic set_lane(input int l, input logic [24:0] raw, input logic [7:0] sh);
    bus.raw_sigs[l]  = raw;
    bus.shift_amt[l] = sh;
    if (l < 4) bus.lane_mask[l] = 1'b1;
  endtask

  // Presents the current beat for one cycle and waits (bounded) for its result.
  task automatic fire(input string tag, input logic [31:0] exp, input logic [31:0] id);
    int cyc;
    @(negedge clk);
    bus.req_id    = id;
    bus.valid_in  = 1'b1;
    bus.ready_out = 1'b1;
    @(negedge clk);
    bus.valid_in = 1'b0;
    cyc = 1;
    while (bus.valid_out !== 1'b1 && cyc < 10) begin
      @(negedge clk);
      cyc++;
    end
    check({tag, "_res"}, bus.result, exp);
    check({tag, "_id"}, bus.req_id_out, id);
    check({tag, "_lat"}, 32'(cyc), 32'd3);
  endtask

  logic [31:0] exp_tab [10] = '{32'h3F80_0000, 32'h4000_0000, 32'h4080_0000, 32'h4100_0000,
                                32'h4180_0000, 32'h4200_0000, 32'h4280_0000, 32'h4300_0000,
                                32'h4380_0000, 32'h4400_0000};

  initial begin
    int sent, rcv, stall_cnt, vld_cnt;
    logic stall, prev_stall;
    logic [31:0] prev_res, prev_id;

    clear_beat();
    bus.ready_out = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_vld", 32'(bus.valid_out), 32'd0);
    check("rst_res", bus.result, 32'h0);
    check("rst_id", bus.req_id_out, 32'h0);
    check("rst_rdy", 32'(bus.ready_in), 32'd1);
    reset_n = 1'b1;

    clear_beat(); set_lane(0, ONE, 0);
    fire("t1_one", 32'h3F80_0000, 1);
    clear_beat(); set_lane(0, ONE, 0); set_lane(1, ONE, 0); set_lane(4, MONE, 0);
    fire("t2_c_cancel", 32'h3F80_0000, 2);
    bus.lane_mask[1] = 1'b0;
    fire("t2_masked", 32'h0000_0000, 3);
    // raw 3 is 3*2^-22, exactly representable in a 23-bit fraction: no rounding occurs.
    clear_beat(); set_lane(0, ONE, 0); set_lane(1, 25'd3, 0);
    fire("t3_exact", 32'h3F80_0006, 4);
    clear_beat(); set_lane(0, ONE, 0); set_lane(1, 25'd1, 2);
    fire("t3_tie_even", 32'h3F80_0000, 5);
    clear_beat(); set_lane(0, ONE, 0); set_lane(1, 25'd1, 1); set_lane(2, 25'd1, 2);
    fire("t3_tie_odd", 32'h3F80_0002, 6);
    clear_beat(); set_lane(0, ONE, 0); set_lane(1, 25'd1, 2); set_lane(2, 25'd1, 5);
    fire("sticky_up", 32'h3F80_0001, 7);
    clear_beat(); set_lane(0, ONE, 0); set_lane(1, 25'd1, 2); set_lane(2, 25'd5, 40);
    fire("bigshift_sticky", 32'h3F80_0001, 8);
    bus.lane_mask[2] = 1'b0;
    fire("masked_no_sticky", 32'h3F80_0000, 9);
    clear_beat(); set_lane(0, 25'h07F_FFFF, 0); set_lane(1, 25'd1, 1); set_lane(2, 25'd1, 2);
    fire("round_carry", 32'h4000_0000, 10);
    clear_beat(); set_lane(0, MONE, 0);
    fire("negative", 32'hBF80_0000, 11);
    clear_beat(); set_lane(0, ONE, 0); set_lane(1, ONE, 1);
    fire("one_half_sum", 32'h3FC0_0000, 12);
    clear_beat(); set_lane(0, 25'd1, 0); bus.max_exp = 10'd149;
    fire("small_p", 32'h3F80_0000, 13);
    clear_beat();
    fire("all_zero", 32'h0000_0000, 14);
    clear_beat(); set_lane(0, ONE, 0); bus.max_exp = 10'd254;
    fire("exp_254", 32'h7F00_0000, 15);
    bus.max_exp = 10'd255;
    fire("exp_255_inf", 32'h7F80_0000, 16);
    bus.max_exp = 10'd400;
    fire("t4_overflow", 32'h7F80_0000, 17);
    bus.max_exp = 10'd1;
    fire("exp_1_min", 32'h0080_0000, 18);
    bus.max_exp = 10'd0;
    fire("exp_0_flush", 32'h0000_0000, 19);
    clear_beat(); set_lane(0, ONE, 0); bus.exceptions.nan = 1'b1; bus.exceptions.inf = 1'b1;
    fire("t4_nan", 32'h7FC0_0000, 20);
    bus.exceptions.nan = 1'b0; bus.exceptions.sign = 1'b1;
    fire("t4_ninf", 32'hFF80_0000, 21);

    // Burst of 10 beats, max_exp stepping by one per beat, ready_out low on cycles 4..8.
    clear_beat(); set_lane(0, ONE, 0);
    sent = 0; rcv = 0; stall_cnt = 0; prev_stall = 1'b0; prev_res = '0; prev_id = '0;
    for (int cyc = 0; cyc < 40 && rcv < 10; cyc++) begin
      @(negedge clk);
      bus.ready_out = !(cyc >= 4 && cyc <= 8);
      bus.valid_in  = (sent < 10);
      bus.max_exp   = 10'(127 + sent);
      bus.req_id    = 32'(200 + sent);
      #1;
      if (prev_stall) begin
        check("t5_hold_vld", 32'(bus.valid_out), 32'd1);
        check("t5_hold_res", bus.result, prev_res);
        check("t5_hold_id", bus.req_id_out, prev_id);
      end
      stall = bus.valid_out && !bus.ready_out;
      if (stall) stall_cnt++;
      check("t5_ready_in", 32'(bus.ready_in), 32'(!stall));
      if (bus.valid_out && bus.ready_out) begin
        check("t5_res", bus.result, exp_tab[rcv]);
        check("t5_id", bus.req_id_out, 32'(200 + rcv));
        rcv++;
      end
      if (bus.valid_in && !stall) sent++;
      prev_stall = stall;
      prev_res   = bus.result;
      prev_id    = bus.req_id_out;
    end
    check("t5_received", 32'(rcv), 32'd10);
    check("t5_sent", 32'(sent), 32'd10);
    check("t5_stall_cycles", 32'(stall_cnt), 32'd5);

    // Reset pulse with two beats in flight.
    @(negedge clk);
    clear_beat(); set_lane(0, ONE, 0);
    bus.ready_out = 1'b1;
    bus.valid_in = 1'b1; bus.req_id = 32'd300;
    @(negedge clk);
    bus.req_id = 32'd301;
    @(negedge clk);
    bus.valid_in = 1'b0;
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    check("t6_vld_after_rst", 32'(bus.valid_out), 32'd0);
    vld_cnt = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (bus.valid_out) vld_cnt++;
    end
    check("t6_no_stale", 32'(vld_cnt), 32'd0);
    fire("t6_after_rst", 32'h3F80_0000, 302);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit, observed no finish, expected finish");
    $fatal(1, "watchdog");
  end
endmodule
